// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory pins of the memory
// port arbiter. The slave view belongs to the arbiter. The master view
// belongs to the requesters and the memory together.
interface mem_port_arbiter_if;
    logic        i_read;
    logic [15:0] i_address;
    logic        i_resp;
    logic [15:0] i_rdata;

    logic        d_read;
    logic        d_write;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [1:0]  d_byte_enable;
    logic        d_resp;
    logic [15:0] d_rdata;

    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;

    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_wdata, d_byte_enable,
        input  mem_resp, mem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata,
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address,
        output d_read, d_write, d_address, d_wdata, d_byte_enable,
        output mem_resp, mem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata,
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single LC-3b memory port between instruction fetch (I) and the
// mem stage (D). D has priority. After STARVE_LIMIT consecutive D grants
// taken while I was waiting, the next contested decision goes to I.
// Arbitration happens only in IDLE, so back-to-back accesses are separated
// by one idle bus cycle.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [3:0] streak;
    logic       d_req;
    logic       grant_d;
    logic       grant_i;

    // Grant decision: D wins unless I has been passed over LIMIT times in a row.
    always_comb begin
        d_req   = bus.d_read | bus.d_write;
        grant_d = (state == IDLE) && d_req && !(bus.i_read && (streak == LIMIT));
        grant_i = (state == IDLE) && bus.i_read && !grant_d;
    end

    // Response routing: only the side that owns the bus sees mem_resp.
    always_comb begin
        bus.i_resp  = (state == SERVE_I) & bus.mem_resp;
        bus.d_resp  = (state == SERVE_D) & bus.mem_resp;
        bus.i_rdata = bus.mem_rdata;
        bus.d_rdata = bus.mem_rdata;
    end

    // Grant latching, service hold until mem_resp, and starvation counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            streak              <= 4'd0;
            bus.mem_read        <= 1'b0;
            bus.mem_write       <= 1'b0;
            bus.mem_byte_enable <= 2'b00;
            bus.mem_address     <= 16'h0000;
            bus.mem_wdata       <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state               <= SERVE_D;
                        bus.mem_read        <= bus.d_read & ~bus.d_write;
                        bus.mem_write       <= bus.d_write;
                        bus.mem_byte_enable <= bus.d_byte_enable;
                        bus.mem_address     <= bus.d_address;
                        bus.mem_wdata       <= bus.d_wdata;
                        if (!bus.i_read) begin
                            streak <= 4'd0;
                        end else if (streak != LIMIT) begin
                            streak <= streak + 4'd1;
                        end
                    end else if (grant_i) begin
                        // Fetch is always a full-word read; write data is left alone.
                        state               <= SERVE_I;
                        bus.mem_read        <= 1'b1;
                        bus.mem_write       <= 1'b0;
                        bus.mem_byte_enable <= 2'b11;
                        bus.mem_address     <= bus.i_address;
                        streak              <= 4'd0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // A requester dropping mid-service is ignored; only mem_resp ends it.
                    if (bus.mem_resp) begin
                        state         <= IDLE;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference
// model checked against the DUT on every falling clock edge.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    endtask

    // Advance to just after the next rising edge; stimulus changes here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: who owns the memory, what was latched at grant, and
    // how many D grants in a row were handed out while fetch was waiting.
    int          m_owner = 0;     // 0 none, 1 fetch, 2 data
    logic        m_rd = 1'b0;
    logic        m_wr = 1'b0;
    logic [1:0]  m_be = 2'b00;
    logic [15:0] m_addr = 16'h0000;
    logic [15:0] m_wdata = 16'h0000;
    int          m_dwins = 0;
    string       m_log = "";

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = 0; m_rd = 0; m_wr = 0; m_be = 2'b00;
            m_addr = 16'h0000; m_wdata = 16'h0000; m_dwins = 0;
        end else if (m_owner == 0) begin
            if ((bus.d_read || bus.d_write) && !(bus.i_read && m_dwins >= LIMIT)) begin
                m_owner = 2;
                m_wr = bus.d_write;
                m_rd = bus.d_read && !bus.d_write;
                m_be = bus.d_byte_enable;
                m_addr = bus.d_address;
                m_wdata = bus.d_wdata;
                m_dwins = bus.i_read ? ((m_dwins + 1 > LIMIT) ? LIMIT : m_dwins + 1) : 0;
                m_log = {m_log, "D"};
            end else if (bus.i_read) begin
                m_owner = 1;
                m_rd = 1; m_wr = 0; m_be = 2'b11;
                m_addr = bus.i_address;
                m_dwins = 0;
                m_log = {m_log, "I"};
            end
        end else if (bus.mem_resp) begin
            m_owner = 0; m_rd = 0; m_wr = 0;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        logic exp_i, exp_d;
        exp_i = (m_owner == 1) && bus.mem_resp;
        exp_d = (m_owner == 2) && bus.mem_resp;
        chk("cyc mem_read", bus.mem_read, m_rd);
        chk("cyc mem_write", bus.mem_write, m_wr);
        chk("cyc mem_byte_enable", bus.mem_byte_enable, m_be);
        chk("cyc mem_address", bus.mem_address, m_addr);
        chk("cyc mem_wdata", bus.mem_wdata, m_wdata);
        chk("cyc i_resp", bus.i_resp, exp_i);
        chk("cyc d_resp", bus.d_resp, exp_d);
        if (exp_i) chk("cyc i_rdata", bus.i_rdata, bus.mem_rdata);
        if (exp_d) chk("cyc d_rdata", bus.d_rdata, bus.mem_rdata);
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_streak [6];
        string      seen;
        int         log_start;
        exp_streak = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

        bus.i_read = 0; bus.i_address = 0;
        bus.d_read = 0; bus.d_write = 0; bus.d_address = 0; bus.d_wdata = 0; bus.d_byte_enable = 0;
        bus.mem_resp = 0; bus.mem_rdata = 0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst mem_read", bus.mem_read, 1'b0);
        chk("rst mem_write", bus.mem_write, 1'b0);
        chk("rst mem_byte_enable", bus.mem_byte_enable, 2'b00);
        chk("rst mem_address", bus.mem_address, 16'h0000);
        chk("rst i_resp", bus.i_resp, 1'b0);
        chk("rst d_resp", bus.d_resp, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Lone fetch read, memory answers on the third service cycle
        bus.i_read = 1; bus.i_address = 16'h0040;
        tick();
        chk("iread mem_read", bus.mem_read, 1'b1);
        chk("iread mem_address", bus.mem_address, 16'h0040);
        chk("iread mem_byte_enable", bus.mem_byte_enable, 2'b11);
        tick(); tick();
        bus.mem_resp = 1; bus.mem_rdata = 16'h1234;
        #1;
        chk("iread i_resp", bus.i_resp, 1'b1);
        chk("iread i_rdata", bus.i_rdata, 16'h1234);
        chk("iread d_resp", bus.d_resp, 1'b0);
        tick();
        bus.mem_resp = 0; bus.i_read = 0;
        chk("iread strobe drop", bus.mem_read, 1'b0);
        tick();

        // Lone data write
        bus.d_write = 1; bus.d_address = 16'h0100; bus.d_wdata = 16'hBEEF; bus.d_byte_enable = 2'b01;
        tick();
        chk("dwr mem_write", bus.mem_write, 1'b1);
        chk("dwr mem_read", bus.mem_read, 1'b0);
        chk("dwr mem_byte_enable", bus.mem_byte_enable, 2'b01);
        chk("dwr mem_wdata", bus.mem_wdata, 16'hBEEF);
        chk("dwr mem_address", bus.mem_address, 16'h0100);
        tick();
        bus.mem_resp = 1;
        #1;
        chk("dwr d_resp", bus.d_resp, 1'b1);
        chk("dwr i_resp", bus.i_resp, 1'b0);
        tick();
        bus.mem_resp = 0; bus.d_write = 0;
        chk("dwr d_resp one cycle", bus.d_resp, 1'b0);
        chk("dwr mem_write drop", bus.mem_write, 1'b0);
        tick();

        // Simultaneous requests: D first, I strobe two cycles after D resp
        bus.i_read = 1; bus.i_address = 16'h0200;
        bus.d_read = 1; bus.d_address = 16'h0300;
        tick();
        chk("both first mem_address", bus.mem_address, 16'h0300);
        chk("both first mem_read", bus.mem_read, 1'b1);
        tick();
        bus.mem_resp = 1; bus.mem_rdata = 16'h5555;
        #1;
        chk("both d_resp", bus.d_resp, 1'b1);
        chk("both d_rdata", bus.d_rdata, 16'h5555);
        chk("both i_resp held", bus.i_resp, 1'b0);
        tick();
        bus.mem_resp = 0; bus.d_read = 0;
        chk("both gap cycle mem_read", bus.mem_read, 1'b0);
        tick();
        chk("both I strobe", bus.mem_read, 1'b1);
        chk("both I address", bus.mem_address, 16'h0200);
        bus.mem_resp = 1; bus.mem_rdata = 16'h6666;
        #1;
        chk("both i_resp", bus.i_resp, 1'b1);
        tick();
        bus.mem_resp = 0; bus.i_read = 0;
        tick();

        // Starvation: both sides request continuously
        log_start = m_log.len();
        seen = "";
        bus.i_read = 1; bus.i_address = 16'h0400;
        bus.d_read = 1; bus.d_address = 16'h1000;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen = {seen, (bus.mem_address >= 16'h1000) ? "D" : "I"};
            chk($sformatf("starve streak %0d", k), dut.streak, exp_streak[k]);
            bus.mem_resp = 1;
            tick();
            bus.mem_resp = 0;
            if (bus.mem_address >= 16'h1000) bus.d_address = bus.d_address + 16'h1;
            else bus.i_address = bus.i_address + 16'h4;
        end
        bus.d_read = 0; bus.i_read = 0;
        chk_str("starve dut grant order", seen, "DDDDID");
        chk_str("starve model grant order", m_log.substr(log_start, log_start + 5), "DDDDID");
        tick();

        // Spurious mem_resp in IDLE
        bus.mem_resp = 1;
        #1;
        chk("spur i_resp", bus.i_resp, 1'b0);
        chk("spur d_resp", bus.d_resp, 1'b0);
        tick();
        bus.mem_resp = 0;
        chk("spur mem_read", bus.mem_read, 1'b0);
        chk("spur mem_write", bus.mem_write, 1'b0);
        tick();

        // Reset in SERVE_D, then a stale mem_resp
        bus.d_write = 1; bus.d_address = 16'h0500; bus.d_wdata = 16'h1111; bus.d_byte_enable = 2'b11;
        tick();
        chk("rstmid mem_write before", bus.mem_write, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid mem_write", bus.mem_write, 1'b0);
        chk("rstmid mem_read", bus.mem_read, 1'b0);
        chk("rstmid mem_byte_enable", bus.mem_byte_enable, 2'b00);
        chk("rstmid mem_address", bus.mem_address, 16'h0000);
        chk("rstmid mem_wdata", bus.mem_wdata, 16'h0000);
        chk("rstmid streak", dut.streak, 4'd0);
        bus.d_write = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        bus.mem_resp = 1;
        #1;
        chk("stale d_resp", bus.d_resp, 1'b0);
        chk("stale i_resp", bus.i_resp, 1'b0);
        tick();
        bus.mem_resp = 0;
        tick();

        // Read and write both set: write wins
        bus.d_read = 1; bus.d_write = 1; bus.d_address = 16'h0600; bus.d_wdata = 16'h2222; bus.d_byte_enable = 2'b10;
        tick();
        chk("rw mem_write", bus.mem_write, 1'b1);
        chk("rw mem_read", bus.mem_read, 1'b0);
        chk("rw mem_byte_enable", bus.mem_byte_enable, 2'b10);
        tick();
        bus.mem_resp = 1;
        #1;
        chk("rw d_resp", bus.d_resp, 1'b1);
        tick();
        bus.mem_resp = 0; bus.d_read = 0; bus.d_write = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
